// File: rtl/hilo_div_controller.sv
// HI/LO register pair with a multi-cycle unsigned restoring divider (DIVU) and MFHI/MFLO/MTHI/MTLO access.
// Optional feature macro: DIV_EARLY_OUT_EN (dividend < nonzero divisor finishes at the accept edge).
module hilo_div_controller #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic             mf_req,
  input  logic             mt_we,
  input  logic             hl_sel,
  input  logic [WIDTH-1:0] mt_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic             dz_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diffLow;
  logic             fits;
  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] quoNext;
  logic             earlyOut;

  // The remainder is always below the divisor, so a successful subtract fits in WIDTH bits.
  always_comb begin
    trial   = {rem_q, quo_q[WIDTH-1]};
    fits    = (trial >= {1'b0, div_q});
    diffLow = trial[WIDTH-1:0] - div_q;
    remNext = fits ? diffLow : trial[WIDTH-1:0];
    quoNext = {quo_q[WIDTH-2:0], fits};
  end

  always_comb begin
`ifdef DIV_EARLY_OUT_EN
    earlyOut = (dataB != '0) && (dataA < dataB);
`else
    earlyOut = 1'b0;
`endif
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    dz_d      = dz_q;
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    stall_req = busy & (start | mf_req | mt_we);

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (mt_we) begin
          if (hl_sel) hi_d = mt_data;
          else        lo_d = mt_data;
        end
        // A divide result written at this edge takes priority over a same-cycle move-to.
        if (start) begin
          div_d   = dataB;
          quo_d   = dataA;
          rem_d   = '0;
          cnt_d   = '0;
          dz_d    = (dataB == '0);
          state_d = RUN;
          if (earlyOut) begin
            hi_d    = dataA;
            lo_d    = '0;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        rem_d = remNext;
        quo_d = quoNext;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LastCnt) begin
          lo_d    = quoNext;
          hi_d    = remNext;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  assign rd_data = hl_sel ? hi_q : lo_q;
  assign dz_flag = dz_q;

endmodule

// File: tb/tb_hilo_div_controller.sv
// Randomised and directed bench for hilo_div_controller, checked every cycle against a quotient/remainder model.
// Honours DIV_EARLY_OUT_EN in the model and in the 5/9 directed case.
module tb_hilo_div_controller;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dataA = '0;
  logic [W-1:0] dataB = '0;
  logic         mf_req = 1'b0;
  logic         mt_we = 1'b0;
  logic         hl_sel = 1'b0;
  logic [W-1:0] mt_data = '0;
  logic [W-1:0] rd_data;
  logic         busy;
  logic         stall_req;
  logic         done;
  logic         dz_flag;

  int compared = 0;
  int mismatched = 0;
  bit checkEn = 1'b0;

  hilo_div_controller #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .dataA(dataA), .dataB(dataB),
    .mf_req(mf_req), .mt_we(mt_we), .hl_sel(hl_sel), .mt_data(mt_data),
    .rd_data(rd_data), .busy(busy), .stall_req(stall_req), .done(done), .dz_flag(dz_flag)
  );

  always #5 clk = ~clk;

  int           mRunLeft = 0;
  bit           mDone = 1'b0;
  bit           mDz = 1'b0;
  logic [W-1:0] mHi = '0;
  logic [W-1:0] mLo = '0;
  logic [W-1:0] pQ = '0;
  logic [W-1:0] pR = '0;

  // Model: a divide is just "W cycles later, HI/LO become a%b and a/b".
  always @(posedge clk) begin
    if (reset) begin
      mRunLeft = 0;
      mDone    = 1'b0;
      mDz      = 1'b0;
      mHi      = '0;
      mLo      = '0;
      checkEn  = 1'b1;
    end else if (mRunLeft > 0) begin
      mRunLeft = mRunLeft - 1;
      mDone    = 1'b0;
      if (mRunLeft == 0) begin
        mHi   = pR;
        mLo   = pQ;
        mDone = 1'b1;
      end
    end else begin
      mDone = 1'b0;
      if (mt_we) begin
        if (hl_sel) mHi = mt_data;
        else        mLo = mt_data;
      end
      if (start) begin
        mDz      = (dataB == 0);
        pQ       = (dataB == 0) ? '1 : dataA / dataB;
        pR       = (dataB == 0) ? dataA : dataA % dataB;
        mRunLeft = W;
`ifdef DIV_EARLY_OUT_EN
        if (dataB != 0 && dataA < dataB) begin
          mRunLeft = 0;
          mHi      = dataA;
          mLo      = '0;
          mDone    = 1'b1;
        end
`endif
      end
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic         expBusy;
  logic [W-1:0] expRd;

  always @(negedge clk) begin
    if (checkEn) begin
      expBusy = (mRunLeft > 0);
      expRd   = hl_sel ? mHi : mLo;
      checkOutput("model busy", busy, expBusy);
      checkOutput("model done", done, mDone);
      checkOutput("model stall_req", stall_req, expBusy & (start | mf_req | mt_we));
      checkOutput("model dz_flag", dz_flag, mDz);
      checkOutput("model rd_data", rd_data, expRd);
    end
  end

  task automatic applyStimulus(input bit st, input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit mf, input bit mt, input bit sel, input logic [W-1:0] md);
    start   = st;
    dataA   = a;
    dataB   = b;
    mf_req  = mf;
    mt_we   = mt;
    hl_sel  = sel;
    mt_data = md;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic readBoth(input string tag, input logic [W-1:0] expLo, input logic [W-1:0] expHi);
    hl_sel = 1'b0;
    #1 checkOutput({tag, " LO"}, rd_data, expLo);
    hl_sel = 1'b1;
    #1 checkOutput({tag, " HI"}, rd_data, expHi);
    hl_sel = 1'b0;
  endtask

  task automatic runDivide(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] expLo, input logic [W-1:0] expHi, input bit expDz);
    applyStimulus(1'b1, a, b, 1'b0, 1'b0, 1'b0, '0);
    nextCycle();
    start = 1'b0;
    for (int i = 1; i <= W; i++) begin
      sample();
      if (i == 1 || i == W) checkOutput({tag, " busy"}, busy, 1);
      nextCycle();
    end
    sample();
    checkOutput({tag, " done"}, done, 1);
    checkOutput({tag, " dz_flag"}, dz_flag, expDz);
    readBoth(tag, expLo, expHi);
    nextCycle();
  endtask

  function automatic logic [W-1:0] randOperand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1, 2:    return W'($urandom_range(1, 20));
      3:       return W'($urandom_range(0, 1000));
      default: return W'($urandom);
    endcase
  endfunction

  bit sawDone;

  initial begin
    // Reset state.
    nextCycle();
    nextCycle();
    reset  = 1'b0;
    mf_req = 1'b1;
    sample();
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset stall_req", stall_req, 0);
    checkOutput("reset dz_flag", dz_flag, 0);
    readBoth("reset", 32'h0, 32'h0);
    nextCycle();
    mf_req = 1'b0;

    runDivide("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    runDivide("div0", 32'h12345678, 32'h0, 32'hFFFFFFFF, 32'h12345678, 1'b1);

    // Dependent MFLO held from t+5 while the divide is running.
    applyStimulus(1'b1, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0, '0);
    nextCycle();
    start = 1'b0;
    for (int i = 1; i <= W; i++) begin
      if (i == 5) mf_req = 1'b1;
      sample();
      if (i == 4) checkOutput("stall before mf", stall_req, 0);
      if (i == 5 || i == W) checkOutput("stall during mf", stall_req, 1);
      nextCycle();
    end
    sample();
    checkOutput("stall released", stall_req, 0);
    checkOutput("mflo after div done", done, 1);
    checkOutput("mflo rd_data", rd_data, 32'hFFFFFFFF);
    hl_sel = 1'b1;
    #1 checkOutput("hi after /1", rd_data, 32'h0);
    hl_sel = 1'b0;
    nextCycle();
    mf_req = 1'b0;

    // Reset in the middle of a run aborts it without a done pulse.
    applyStimulus(1'b1, 32'd1000, 32'd3, 1'b0, 1'b0, 1'b0, '0);
    nextCycle();
    start = 1'b0;
    for (int i = 0; i < 9; i++) nextCycle();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    sample();
    checkOutput("abort busy", busy, 0);
    checkOutput("abort done", done, 0);
    readBoth("abort", 32'h0, 32'h0);
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      nextCycle();
      sample();
      if (done) sawDone = 1'b1;
    end
    checkOutput("abort no done pulse", sawDone, 0);
    nextCycle();

    // Move-to then move-from, and a move-to racing a divide accept.
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 32'hDEAD0000);
    nextCycle();
    mt_we  = 1'b0;
    mf_req = 1'b1;
    hl_sel = 1'b1;
    sample();
    checkOutput("mthi/mfhi", rd_data, 32'hDEAD0000);
    nextCycle();
    applyStimulus(1'b1, 32'd40, 32'd9, 1'b0, 1'b1, 1'b0, 32'h1111);
    nextCycle();
    start = 1'b0;
    mt_we = 1'b0;
    sample();
    checkOutput("mtlo with start", rd_data, 32'h1111);
    for (int i = 0; i < W; i++) nextCycle();
    sample();
    checkOutput("40/9 done", done, 1);
    readBoth("40/9", 32'd4, 32'd4);
    nextCycle();

    // Back-to-back issue in the DONE cycle.
    applyStimulus(1'b1, 32'd50, 32'd6, 1'b0, 1'b0, 1'b0, '0);
    nextCycle();
    start = 1'b0;
    for (int i = 0; i < W; i++) nextCycle();
    applyStimulus(1'b1, 32'd77, 32'd5, 1'b0, 1'b0, 1'b0, '0);
    sample();
    checkOutput("50/6 done", done, 1);
    readBoth("50/6", 32'd8, 32'd2);
    nextCycle();
    start = 1'b0;
    sample();
    checkOutput("back-to-back busy", busy, 1);
    for (int i = 0; i < W; i++) nextCycle();
    sample();
    checkOutput("77/5 done", done, 1);
    readBoth("77/5", 32'd15, 32'd2);
    nextCycle();

`ifdef DIV_EARLY_OUT_EN
    applyStimulus(1'b1, 32'd5, 32'd9, 1'b1, 1'b0, 1'b0, '0);
    nextCycle();
    start = 1'b0;
    sample();
    checkOutput("5/9 early done", done, 1);
    checkOutput("5/9 early busy", busy, 0);
    checkOutput("5/9 early stall", stall_req, 0);
    readBoth("5/9 early", 32'd0, 32'd5);
    nextCycle();
    mf_req = 1'b0;
`else
    runDivide("5/9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0);
`endif

    // Random traffic, checked against the model every cycle.
    for (int c = 0; c < 1500; c++) begin
      reset   = ($urandom_range(0, 299) == 0);
      start   = ($urandom_range(0, 5) == 0);
      dataA   = randOperand();
      dataB   = randOperand();
      mf_req  = ($urandom_range(0, 3) == 0);
      mt_we   = ($urandom_range(0, 5) == 0);
      hl_sel  = $urandom_range(0, 1) == 1;
      mt_data = W'($urandom);
      nextCycle();
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) nextCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
